alu_unit: RTL and testbench

//   16-bit signed (two's-complement) ALU for the datapath.
//   ADD, SUB and MUL complete in one cycle; DIV uses a 16-cycle iterative divider.

---
 rtl/alu_unit.sv | 114 +++++++++++
 tb/tb_alu_unit.sv | 125 ++++++++++++
 2 files changed

// File: rtl/alu_unit.sv
// alu_unit: 16-bit signed ALU. ADD/SUB/MUL finish on the launch edge; DIV runs
// an iterative restoring divide on operand magnitudes and finishes 16 edges later.
// Ports:
//   Clock      rising-edge clock
//   Reset      async active-low reset
//   Start      launch strobe (only accepted while idle)
//   ALUOP[1:0] 00 ADD, 01 SUB, 10 MUL, 11 DIV
//   A, B       signed operands
//   Result     registered signed result, held until next completion
//   Done       1 = idle / Result valid, 0 = divide in progress
module alu_unit #(
  parameter int WIDTH = 16
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start,
  input  logic [1:0]       ALUOP,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Result,
  output logic             Done
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic {IDLE, DIV_BUSY} state_t;

  state_t           state, state_nxt;
  logic             armed;      // blocks a launch on the edge that releases reset
  logic [WIDTH-1:0] rem, quo, dvs;
  logic             neg_q, dvz;
  logic [CW-1:0]    cnt;

  logic             launch, last;
  logic [WIDTH-1:0] a_mag, b_mag, mul_lo, quo_nxt, rem_nxt, div_res;
  logic [WIDTH:0]   rem_sh, rem_sub;
  logic             q_bit;

  assign launch = (state == IDLE) && Start && armed;
  assign last   = (state == DIV_BUSY) && (cnt == CW'(WIDTH-1));
  assign Done   = (state == IDLE);

  // -MIN wraps back to MIN, whose unsigned reading is the correct magnitude.
  assign a_mag  = A[WIDTH-1] ? -A : A;
  assign b_mag  = B[WIDTH-1] ? -B : B;
  // Low half of the product is identical for signed and unsigned operands.
  assign mul_lo = A * B;

  // One restoring step. The remainder is always below the divisor, so the
  // shifted value is below twice the divisor and the top bit of the
  // difference is a clean borrow flag.
  always_comb begin
    rem_sh  = {rem, quo[WIDTH-1]};
    rem_sub = rem_sh - {1'b0, dvs};
    q_bit   = ~rem_sub[WIDTH];
    rem_nxt = q_bit ? rem_sub[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    quo_nxt = {quo[WIDTH-2:0], q_bit};
    if (dvz)        div_res = '1;
    else if (neg_q) div_res = -quo_nxt;
    else            div_res = quo_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (launch && ALUOP == 2'b11) state_nxt = DIV_BUSY;
      DIV_BUSY: if (last) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state <= IDLE;
      armed <= 1'b0;
    end else begin
      state <= state_nxt;
      armed <= 1'b1;
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      Result <= '0;
      rem    <= '0;
      quo    <= '0;
      dvs    <= '0;
      neg_q  <= 1'b0;
      dvz    <= 1'b0;
      cnt    <= '0;
    end else if (launch) begin
      case (ALUOP)
        2'b00: Result <= A + B;
        2'b01: Result <= A - B;
        2'b10: Result <= mul_lo;
        default: begin
          // Dividend magnitude shifts out of quo as quotient bits shift in.
          rem   <= '0;
          quo   <= a_mag;
          dvs   <= b_mag;
          neg_q <= A[WIDTH-1] ^ B[WIDTH-1];
          dvz   <= (B == '0);
          cnt   <= '0;
        end
      endcase
    end else if (state == DIV_BUSY) begin
      rem <= rem_nxt;
      quo <= quo_nxt;
      cnt <= cnt + 1'b1;
      if (last) Result <= div_res;
    end
  end

endmodule

// File: tb/tb_alu_unit.sv
// tb_alu_unit: directed-vector bench for alu_unit with hand-computed results.
module tb_alu_unit;

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic        Start = 1'b0;
  logic [1:0]  ALUOP = 2'b00;
  logic [15:0] A = '0, B = '0;
  logic [15:0] Result;
  logic        Done;

  int n_chk = 0;
  int n_fail = 0;

  alu_unit #(.WIDTH(16)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .ALUOP(ALUOP),
    .A(A), .B(B), .Result(Result), .Done(Done)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Single-cycle op: drive at negedge, check 1ns after the launch edge.
  task automatic op1(input string tag, input logic [1:0] op,
                     input logic [15:0] a, input logic [15:0] b, input logic [15:0] exp);
    @(negedge Clock);
    ALUOP = op; A = a; B = b; Start = 1'b1;
    @(posedge Clock); #1;
    Start = 1'b0;
    chk({tag, "_res"}, Result, exp);
    chk({tag, "_done"}, {15'd0, Done}, 16'd1);
  endtask

  // Divide; inputs are scrambled after launch, optionally with a stray Start.
  task automatic opdiv(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] exp, input logic [15:0] prev, input bit poke);
    @(negedge Clock);
    ALUOP = 2'b11; A = a; B = b; Start = 1'b1;
    @(posedge Clock); #1;
    Start = 1'b0;
    ALUOP = 2'b00; A = 16'h1234; B = 16'h0001;
    chk({tag, "_busy0"}, {15'd0, Done}, 16'd0);
    for (int i = 1; i <= 15; i++) begin
      if (poke && i == 7) Start = 1'b1;
      @(posedge Clock); #1;
      Start = 1'b0;
      chk({tag, "_busy"}, {15'd0, Done}, 16'd0);
      if (i == 1 || i == 7) chk({tag, "_hold"}, Result, prev);
    end
    @(posedge Clock); #1;
    chk({tag, "_res"}, Result, exp);
    chk({tag, "_done"}, {15'd0, Done}, 16'd1);
  endtask

  initial begin
    repeat (2) @(posedge Clock);
    #1;
    chk("rst_res", Result, 16'd0);
    chk("rst_done", {15'd0, Done}, 16'd1);
    @(negedge Clock);
    Reset = 1'b1;
    @(posedge Clock); #1;
    chk("post_rst_res", Result, 16'd0);

    op1("add1", 2'b00, 16'd100, 16'd23, 16'd123);
    op1("add2", 2'b00, -16'sd50, -16'sd30, -16'sd80);
    op1("add_ovf", 2'b00, 16'd32767, 16'd1, 16'h8000);
    op1("sub1", 2'b01, 16'd23, 16'd100, -16'sd77);
    op1("mul1", 2'b10, 16'd12, 16'd10, 16'd120);
    op1("mul2", 2'b10, 16'd255, 16'd255, 16'hFE01);
    op1("mul3", 2'b10, -16'sd12, 16'd10, -16'sd120);
    op1("mul4", 2'b10, -16'sd25, -16'sd4, 16'd100);

    // Idle with Start low holds Result.
    @(posedge Clock); @(posedge Clock); #1;
    chk("idle_hold", Result, 16'd100);

    // Start held high launches on consecutive edges.
    @(negedge Clock);
    ALUOP = 2'b00; A = 16'd1; B = 16'd2; Start = 1'b1;
    @(posedge Clock); #1;
    chk("hold_start1", Result, 16'd3);
    A = 16'd5;
    @(posedge Clock); #1;
    Start = 1'b0;
    chk("hold_start2", Result, 16'd7);

    opdiv("div1", 16'd100, 16'd3, 16'd33, 16'd7, 1'b0);
    opdiv("div2", -16'sd100, 16'd3, -16'sd33, 16'd33, 1'b1);
    opdiv("div3", 16'd1000, -16'sd5, -16'sd200, -16'sd33, 1'b0);
    opdiv("div4", 16'd0, 16'd5, 16'd0, -16'sd200, 1'b0);
    opdiv("div5", 16'd32767, 16'd1, 16'd32767, 16'd0, 1'b0);
    opdiv("div6", 16'd1, 16'd0, 16'hFFFF, 16'd32767, 1'b0);
    opdiv("div7", 16'h8000, 16'hFFFF, 16'h8000, 16'hFFFF, 1'b0);
    opdiv("div8", -16'sd7, 16'd0, 16'hFFFF, 16'h8000, 1'b0);

    // Reset mid-divide aborts immediately.
    @(negedge Clock);
    ALUOP = 2'b11; A = 16'd500; B = 16'd7; Start = 1'b1;
    @(posedge Clock); #1;
    Start = 1'b0;
    repeat (4) @(posedge Clock);
    #3;
    chk("mid_busy", {15'd0, Done}, 16'd0);
    Reset = 1'b0;
    #1;
    chk("mid_rst_res", Result, 16'd0);
    chk("mid_rst_done", {15'd0, Done}, 16'd1);
    @(negedge Clock);
    Reset = 1'b1;
    @(posedge Clock); #1;
    op1("after_rst", 2'b01, 16'd10, 16'd4, 16'd6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
